// File: rtl/vblank_scheduler_if.sv
// Request/grant bundle shared by the frame-update clients and the vblank scheduler.
interface vblank_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] gnt;

    modport master (output req, output done, input gnt);
    modport slave  (input req, input done, output gnt);
endinterface

// File: rtl/vblank_scheduler.sv
// Grants one client at a time during vertical blank, round-robin within each frame,
// with a per-grant timeout and sticky timeout/overrun error flags.
module vblank_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int VBLANK_LINE = 480,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [9:0]           y,
    input  logic                 clr_err,
    vblank_scheduler_if.slave    bus,
    output logic                 in_vblank,
    output logic [7:0]           frame_cnt,
    output logic [NUM_REQ-1:0]   timeout_err,
    output logic                 overrun
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [9:0]    VB_LINE  = 10'(VBLANK_LINE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]       gidx_q, gidx_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  served_q, served_d;
    logic                in_vblank_q, in_vblank_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [NUM_REQ-1:0]  timeout_err_q, timeout_err_d;
    logic                overrun_q, overrun_d;

    logic                vb_now, vb_rise, vb_fall;
    logic [NUM_REQ-1:0]  eligible;
    logic                arb_found;
    logic [IW-1:0]       arb_idx;
    int                  cand;
    logic                done_hit, timeout_hit;
    logic [NUM_REQ-1:0]  to_set;
    logic                ovr_set;

    assign vb_now   = (y >= VB_LINE);
    assign vb_rise  = vb_now & ~in_vblank_q;
    assign vb_fall  = ~vb_now & in_vblank_q;
    assign eligible = bus.req & ~served_q;

    // First eligible client at or after rr_ptr, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!arb_found && eligible[cand[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IW-1:0];
            end
        end
    end

    assign done_hit    = bus.done[gidx_q];
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        served_d      = served_q;
        in_vblank_d   = vb_now;
        frame_cnt_d   = frame_cnt_q;
        timeout_err_d = timeout_err_q;
        overrun_d     = overrun_q;
        to_set        = '0;
        ovr_set       = 1'b0;

        if (vb_rise) begin
            served_d = '0;
        end

        if (!enable) begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
        end else begin
            if (vb_rise) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            // The client still holding the grant is not counted as left behind.
            ovr_set = vb_fall & (|(eligible & ~gnt_q));

            case (state_q)
                IDLE: begin
                    if (in_vblank_q) begin
                        state_d = ARB;
                    end
                end
                ARB: begin
                    if (!in_vblank_q) begin
                        state_d = IDLE;
                    end else if (arb_found) begin
                        state_d = GRANT;
                        gnt_d   = NUM_REQ'(1) << arb_idx;
                        gidx_d  = arb_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                GRANT: begin
                    if (done_hit || timeout_hit) begin
                        gnt_d            = '0;
                        cnt_d            = '0;
                        served_d[gidx_q] = 1'b1;
                        rr_ptr_d         = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
                        state_d          = in_vblank_q ? ARB : IDLE;
                        if (!done_hit) begin
                            to_set[gidx_q] = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if (!in_vblank_q) begin
                        state_d = IDLE;
                    end else if (|eligible) begin
                        state_d = ARB;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            endcase

            // A clear pulse loses to an error raised on the same cycle.
            if (clr_err) begin
                timeout_err_d = '0;
                overrun_d     = 1'b0;
            end
            timeout_err_d = timeout_err_d | to_set;
            overrun_d     = overrun_d | ovr_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            gidx_q        <= '0;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            served_q      <= '0;
            in_vblank_q   <= 1'b0;
            frame_cnt_q   <= '0;
            timeout_err_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gidx_q        <= gidx_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            served_q      <= served_d;
            in_vblank_q   <= in_vblank_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign in_vblank   = in_vblank_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_vblank_scheduler.sv
// Directed bench for vblank_scheduler: frame arbitration order, round-robin wrap,
// timeout, overrun, enable and reset behaviour with hand-computed expectations.
module tb_vblank_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clr_err;
    logic [9:0] y;
    logic       in_vblank;
    logic [7:0] frame_cnt;
    logic [3:0] timeout_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    vblank_scheduler_if #(.NUM_REQ(4)) bus ();

    vblank_scheduler #(
        .NUM_REQ(4),
        .VBLANK_LINE(480),
        .TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .y(y),
        .clr_err(clr_err),
        .bus(bus),
        .in_vblank(in_vblank),
        .frame_cnt(frame_cnt),
        .timeout_err(timeout_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [9:0] yv, input int n);
        bus.req = r;
        y = yv;
        tick(n);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Holds done low for three cycles of the grant, pulses it on the fourth.
    task automatic serveGrant(input int idx, input string tag);
        logic [3:0] exp;
        exp = 4'(1 << idx);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("%s_gnt_c%0d", tag, c), 32'(bus.gnt), 32'(exp));
            if (c == 3) bus.done = exp;
            tick(1);
        end
        bus.done = '0;
        checkOutput({tag, "_gnt_drop"}, 32'(bus.gnt), 32'h0);
    endtask

    task automatic startFrame(input logic [3:0] r, input logic [7:0] expFrame, input string tag);
        applyStimulus(r, 10'd480, 3);
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(expFrame));
    endtask

    task automatic endFrame(input string tag);
        applyStimulus(4'b0000, 10'd0, 2);
        checkOutput({tag, "_in_vblank"}, 32'(in_vblank), 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        clr_err  = 1'b0;
        y        = 10'd0;
        bus.req  = '0;
        bus.done = '0;
        tick(2);
        checkOutput("rst_gnt",         32'(bus.gnt),     32'h0);
        checkOutput("rst_in_vblank",   32'(in_vblank),   32'h0);
        checkOutput("rst_frame_cnt",   32'(frame_cnt),   32'h0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'h0);
        checkOutput("rst_overrun",     32'(overrun),     32'h0);
        rst = 1'b0;

        // Full frame: all four clients served in order.
        applyStimulus(4'b1111, 10'd479, 1);
        checkOutput("f1_pre_in_vblank", 32'(in_vblank), 32'h0);
        checkOutput("f1_pre_frame_cnt", 32'(frame_cnt), 32'h0);
        applyStimulus(4'b1111, 10'd480, 1);
        checkOutput("f1_in_vblank", 32'(in_vblank), 32'h1);
        checkOutput("f1_frame_cnt", 32'(frame_cnt), 32'h1);
        checkOutput("f1_gnt_idle",  32'(bus.gnt),   32'h0);
        tick(1);
        checkOutput("f1_gnt_arb",   32'(bus.gnt),   32'h0);
        tick(1);
        serveGrant(0, "f1_c0");
        tick(1);
        serveGrant(1, "f1_c1");
        tick(1);
        serveGrant(2, "f1_c2");
        tick(1);
        serveGrant(3, "f1_c3");
        tick(1);
        checkOutput("f1_drain_gnt", 32'(bus.gnt), 32'h0);
        checkOutput("f1_overrun",   32'(overrun), 32'h0);
        endFrame("f1_end");
        checkOutput("f1_end_overrun", 32'(overrun), 32'h0);

        // Round-robin pointer wraps from 2 back to 0.
        startFrame(4'b0010, 8'd2, "f2");
        serveGrant(1, "f2_c1");
        endFrame("f2_end");
        startFrame(4'b0011, 8'd3, "f3");
        serveGrant(0, "f3_wrap_c0");
        tick(1);
        serveGrant(1, "f3_c1");
        endFrame("f3_end");

        // Client 2 never completes: grant times out after 1024 cycles.
        startFrame(4'b0100, 8'd4, "f4");
        tick(1023);
        checkOutput("to_gnt_held",     32'(bus.gnt),     32'h4);
        checkOutput("to_err_pending",  32'(timeout_err), 32'h0);
        tick(1);
        checkOutput("to_gnt_dropped",  32'(bus.gnt),     32'h0);
        checkOutput("to_err_set",      32'(timeout_err), 32'h4);
        bus.req = 4'b0000;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checkOutput("to_err_cleared",  32'(timeout_err), 32'h0);
        endFrame("f4_end");

        // done coincides with the timeout cycle: done wins.
        startFrame(4'b0010, 8'd5, "f5");
        tick(1023);
        checkOutput("tie_gnt_held", 32'(bus.gnt), 32'h2);
        bus.done = 4'b0010;
        tick(1);
        bus.done = 4'b0000;
        checkOutput("tie_gnt_dropped", 32'(bus.gnt),     32'h0);
        checkOutput("tie_no_err",      32'(timeout_err), 32'h0);
        endFrame("f5_end");

        // Vblank ends during client 0's grant while client 3 waits.
        startFrame(4'b0001, 8'd6, "f6");
        checkOutput("ovr_gnt0", 32'(bus.gnt), 32'h1);
        applyStimulus(4'b1001, 10'd524, 1);
        checkOutput("ovr_gnt0_524", 32'(bus.gnt), 32'h1);
        applyStimulus(4'b1001, 10'd0, 1);
        checkOutput("ovr_in_vblank", 32'(in_vblank), 32'h0);
        checkOutput("ovr_flag",      32'(overrun),   32'h1);
        checkOutput("ovr_gnt_kept",  32'(bus.gnt),   32'h1);
        bus.done = 4'b0001;
        tick(1);
        bus.done = 4'b0000;
        checkOutput("ovr_gnt_done", 32'(bus.gnt), 32'h0);
        tick(3);
        checkOutput("ovr_no_c3",    32'(bus.gnt), 32'h0);
        bus.req = 4'b0000;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        checkOutput("ovr_cleared", 32'(overrun), 32'h0);

        // enable drop mid-grant, then reset mid-grant.
        startFrame(4'b0001, 8'd7, "f7");
        checkOutput("en_gnt0", 32'(bus.gnt), 32'h1);
        enable = 1'b0;
        tick(1);
        checkOutput("en_gnt_off",   32'(bus.gnt),   32'h0);
        checkOutput("en_frame_cnt", 32'(frame_cnt), 32'h7);
        tick(2);
        checkOutput("en_gnt_stays_off", 32'(bus.gnt), 32'h0);
        enable = 1'b1;
        tick(2);
        checkOutput("en_regrant", 32'(bus.gnt), 32'h1);
        tick(1);
        rst = 1'b1;
        tick(1);
        checkOutput("rst2_gnt",         32'(bus.gnt),     32'h0);
        checkOutput("rst2_in_vblank",   32'(in_vblank),   32'h0);
        checkOutput("rst2_frame_cnt",   32'(frame_cnt),   32'h0);
        checkOutput("rst2_timeout_err", 32'(timeout_err), 32'h0);
        checkOutput("rst2_overrun",     32'(overrun),     32'h0);
        rst = 1'b0;
        bus.req = 4'b0000;
        tick(1);
        checkOutput("post_rst_frame_cnt", 32'(frame_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vblank_scheduler.md
VBLANK_SCHEDULER -- requirements
Module: vblank_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the frame-update window.
REQ-002 Parameter VBLANK_LINE, default 480: first vertical line outside active video.
REQ-003 Parameter TIMEOUT, default 1024: maximum grant length in clk cycles.
REQ-004 clk  in  1  pixel clock; the only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  scheduler run enable.
REQ-007 y  in  10  current line count from the VGA timing generator.
REQ-008 req  in  NUM_REQ  per-client update request, level.
REQ-009 done  in  NUM_REQ  per-client completion pulse; valid only while that client is granted.
REQ-010 clr_err  in  1  one-cycle pulse that clears the sticky error flags.
REQ-011 gnt  out  NUM_REQ  one-hot grant; all-zero when no grant is active.
REQ-012 in_vblank  out  1  registered flag, high when y >= VBLANK_LINE.
REQ-013 frame_cnt  out  8  count of vblank entries.
REQ-014 timeout_err  out  NUM_REQ  sticky flag per client whose grant timed out.
REQ-015 overrun  out  1  sticky flag, set when a request is left unserved at the end of vblank.

Function
REQ-016 in_vblank SHALL equal the value of (y >= VBLANK_LINE) sampled on the previous clk edge.
REQ-017 The vblank entry event is a rising edge of in_vblank; on it, frame_cnt SHALL increment by 1 (modulo 256) and the per-frame served mask SHALL clear.
REQ-018 FSM states are IDLE, ARB, GRANT and DRAIN.
REQ-019 The FSM SHALL stay in IDLE while in_vblank=0.
REQ-020 IDLE SHALL move to ARB when in_vblank=1.
REQ-021 ARB SHALL pick the first requester with req=1 and served=0, searching round-robin from pointer rr_ptr.
REQ-022 If ARB finds a requester, it SHALL move to GRANT and assert gnt[i] on the next cycle (one-cycle arbitration latency); if none is found, it SHALL move to DRAIN.
REQ-023 In GRANT, gnt[i] SHALL be held, and req[i] SHALL be ignored, until done[i]=1 or the grant cycle counter reaches TIMEOUT-1.
REQ-024 gnt[i] SHALL deassert on the cycle after done[i] or the timeout.
REQ-025 On leaving GRANT, served[i] SHALL be set, rr_ptr SHALL be set to (i+1) mod NUM_REQ, and the FSM SHALL return to ARB if in_vblank=1, otherwise go to IDLE.
REQ-026 A grant in progress SHALL NOT be revoked when vblank ends; no new grant SHALL start while in_vblank=0.
REQ-027 On timeout, timeout_err[i] SHALL be set; if done[i]=1 on the timeout cycle, done wins and no error is flagged.
REQ-028 DRAIN SHALL return to ARB when a new eligible req rises during vblank, and SHALL go to IDLE when in_vblank falls.
REQ-029 On the falling edge of in_vblank, overrun SHALL be set if any req[j]=1 with served[j]=0, excluding the client currently granted.
REQ-030 clr_err=1 SHALL clear timeout_err and overrun; a new error set on the same cycle SHALL take precedence.
REQ-031 enable=0 SHALL force the FSM to IDLE and gnt to 0 on the next cycle; frame_cnt, the sticky flags and rr_ptr SHALL hold.
REQ-032 At most one gnt bit SHALL be high at any time.
REQ-033 The grant cycle counter is ceil(log2(TIMEOUT)) bits wide and resets to 0 on each grant.

Reset
REQ-034 When rst=1 at a clk edge, the following SHALL take effect on that edge: state=IDLE, gnt=0, in_vblank=0, frame_cnt=0, timeout_err=0, overrun=0, served=0, rr_ptr=0, grant counter=0.
REQ-035 A reset during GRANT SHALL drop gnt on the same edge with no error flagged.

Verification
REQ-036 req=4'b1111, each client pulses done 3 cycles after its grant, y steps 479->480 -> gnt order 0001, 0010, 0100, 1000, each grant 4 cycles long, frame_cnt 0->1, overrun=0.
REQ-037 Next frame, after a last grant to client 1, with req=4'b0011 -> first grant goes to client 0 (rr_ptr=2 wraps to 0).
REQ-038 Client 2 granted and never asserts done -> gnt[2] drops after 1024 cycles, timeout_err=4'b0100; a clr_err pulse then clears it.
REQ-039 req[3] held high while y wraps 524->0 during a client-0 grant -> grant 0 completes, client 3 is never granted, overrun=1.
REQ-040 enable falls mid-grant -> gnt=0 next cycle; rst mid-grant -> all outputs zero on that edge.
REQ-041 done[1] and the timeout occur on the same cycle -> gnt[1] drops, timeout_err[1] stays 0.
